// File: rtl/regfile_pkg.sv
// Shared register-class encodings and the flat busy-index mapping used by the
// register bank and its pending-write scoreboard.
package regfile_pkg;

  typedef enum logic [1:0] {
    SEL_GP = 2'b00,
    SEL_SP = 2'b01,
    SEL_IH = 2'b10,
    SEL_T  = 2'b11
  } reg_sel_e;

  localparam int unsigned NUM_SPECIAL = 3;

  // Special registers sit directly above the GP block in the busy vector.
  function automatic int unsigned busy_idx(input logic [1:0]  sel,
                                           input int unsigned addr,
                                           input int unsigned gp_count);
    case (sel)
      SEL_GP:  busy_idx = addr;
      SEL_SP:  busy_idx = gp_count;
      SEL_IH:  busy_idx = gp_count + 1;
      default: busy_idx = gp_count + 2;
    endcase
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: issue sets, writeback clears, flush wipes.
// Priority on one edge is flush > set > clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned GP_ADDR_W = 3,
  localparam int unsigned GP_COUNT  = 2**GP_ADDR_W,
  localparam int unsigned NUM_BUSY  = GP_COUNT + NUM_SPECIAL
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 set_en,
  input  logic [1:0]           set_sel,
  input  logic [GP_ADDR_W-1:0] set_addr,
  input  logic                 clr_en,
  input  logic [1:0]           clr_sel,
  input  logic [GP_ADDR_W-1:0] clr_addr,
  input  logic                 flush,
  output logic [NUM_BUSY-1:0]  busy
);

  logic [NUM_BUSY-1:0] set_mask;
  logic [NUM_BUSY-1:0] clr_mask;
  logic [NUM_BUSY-1:0] busy_next;
  int unsigned         set_idx;
  int unsigned         clr_idx;

  assign set_idx = busy_idx(set_sel, 32'(set_addr), GP_COUNT);
  assign clr_idx = busy_idx(clr_sel, 32'(clr_addr), GP_COUNT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    set_mask = '0;
    clr_mask = '0;
    for (int unsigned i = 0; i < NUM_BUSY; i++) begin
      if (set_en && (set_idx == i)) set_mask[i] = 1'b1;
      if (clr_en && (clr_idx == i)) clr_mask[i] = 1'b1;
    end
    // A newer producer issuing on the same edge as the older one retires
    // must leave the register pending, so set is applied after clear.
    if (flush) busy_next = '0;
    else       busy_next = (busy & ~clr_mask) | set_mask;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!RST_N) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/regfile_bank.sv
// Parametrised GP/SP/IH/T register file with independent bypassing read ports
// and a pending-write scoreboard for the hazard unit.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int unsigned         DATA_W    = 16,
  parameter int unsigned         GP_ADDR_W = 3,
  parameter int unsigned         NUM_RD    = 2,
  parameter logic [DATA_W-1:0]   SP_RST    = '0
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          wr_en,
  input  logic [1:0]                    wr_sel,
  input  logic [GP_ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [2*NUM_RD-1:0]           rd_sel,
  input  logic [GP_ADDR_W*NUM_RD-1:0]   rd_addr,
  output logic [DATA_W*NUM_RD-1:0]      rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic                          sb_set_en,
  input  logic [1:0]                    sb_set_sel,
  input  logic [GP_ADDR_W-1:0]          sb_set_addr,
  input  logic                          flush
);

  localparam int unsigned GP_COUNT = 2**GP_ADDR_W;
  localparam int unsigned NUM_BUSY = GP_COUNT + NUM_SPECIAL;

  logic [DATA_W-1:0]   gp_q [GP_COUNT];
  logic [DATA_W-1:0]   sp_q;
  logic [DATA_W-1:0]   ih_q;
  logic [DATA_W-1:0]   t_q;
  logic [NUM_BUSY-1:0] busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the GP array is reset explicitly because reads after reset must
      // return zero; a plain RAM macro could not be used here.
      for (int unsigned i = 0; i < GP_COUNT; i++) gp_q[i] <= '0;
      sp_q <= SP_RST;
      ih_q <= '0;
      t_q  <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        SEL_GP:  gp_q[wr_addr] <= wr_data;
        SEL_SP:  sp_q          <= wr_data;
        SEL_IH:  ih_q          <= wr_data;
        default: t_q           <= wr_data;
      endcase
    end
  end

  regfile_scoreboard #(
    .GP_ADDR_W (GP_ADDR_W)
  ) u_scoreboard (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .set_en   (sb_set_en),
    .set_sel  (sb_set_sel),
    .set_addr (sb_set_addr),
    .clr_en   (wr_en),
    .clr_sel  (wr_sel),
    .clr_addr (wr_addr),
    .flush    (flush),
    .busy     (busy)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [1:0]           sel;
    logic [GP_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    stored;
    logic                 hit;
    logic                 busy_bit;
    int unsigned          idx;

    assign sel  = rd_sel[2*p +: 2];
    assign addr = rd_addr[GP_ADDR_W*p +: GP_ADDR_W];
    assign idx  = busy_idx(sel, 32'(addr), GP_COUNT);

    // The address only disambiguates within the GP class.
    assign hit = wr_en && (sel == wr_sel) && ((sel != SEL_GP) || (addr == wr_addr));

    always_comb begin
      case (sel)
        SEL_GP:  stored = gp_q[addr];
        SEL_SP:  stored = sp_q;
        SEL_IH:  stored = ih_q;
        default: stored = t_q;
      endcase
    end

    always_comb begin
      busy_bit = 1'b0;
      for (int unsigned i = 0; i < NUM_BUSY; i++) begin
        if (idx == i) busy_bit = busy[i];
      end
    end

    // A write landing this cycle both supplies the data and retires the producer.
    assign rd_data[DATA_W*p +: DATA_W] = hit ? wr_data : stored;
    assign rd_busy[p]                  = busy_bit && !hit;
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: directed scenarios plus randomized
// traffic compared against a flat-array register/busy model.
module tb_regfile_bank;

  localparam int DW     = 16;
  localparam int AW     = 3;
  localparam int NRD    = 2;
  localparam int NGP    = 8;
  localparam int NREG   = NGP + 3;
  localparam logic [DW-1:0] SP_INIT = 16'hBF00;

  logic              CLK;
  logic              RST_N;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [2*NRD-1:0]  rd_sel;
  logic [AW*NRD-1:0] rd_addr;
  logic [DW*NRD-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              sb_set_en;
  logic [1:0]        sb_set_sel;
  logic [AW-1:0]     sb_set_addr;
  logic              flush;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: every register in one flat array, SP/IH/T at 8/9/10.
  logic [DW-1:0] m_reg  [NREG];
  bit            m_busy [NREG];

  regfile_bank #(
    .DATA_W    (DW),
    .GP_ADDR_W (AW),
    .NUM_RD    (NRD),
    .SP_RST    (SP_INIT)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_sel      (rd_sel),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .sb_set_en   (sb_set_en),
    .sb_set_sel  (sb_set_sel),
    .sb_set_addr (sb_set_addr),
    .flush       (flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int flat(input logic [1:0] sel, input logic [AW-1:0] addr);
    if (sel == 2'b00) return int'(addr);
    return NGP - 1 + int'(sel);
  endfunction

  function automatic bit port_hit(input int p);
    logic [1:0]    s;
    logic [AW-1:0] a;
    s = rd_sel[2*p +: 2];
    a = rd_addr[AW*p +: AW];
    return wr_en && flat(s, a) == flat(wr_sel, wr_addr);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int p);
    if (port_hit(p)) return wr_data;
    return m_reg[flat(rd_sel[2*p +: 2], rd_addr[AW*p +: AW])];
  endfunction

  function automatic logic exp_busy(input int p);
    return m_busy[flat(rd_sel[2*p +: 2], rd_addr[AW*p +: AW])] && !port_hit(p);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_reg[NGP] = SP_INIT;
  endtask

  // Apply what the DUT will do on the coming edge; inputs are stable until then.
  task automatic model_commit();
    if (wr_en) begin
      m_reg[flat(wr_sel, wr_addr)]  = wr_data;
      m_busy[flat(wr_sel, wr_addr)] = 1'b0;
    end
    if (sb_set_en) m_busy[flat(sb_set_sel, sb_set_addr)] = 1'b1;
    if (flush) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
  endtask

  task automatic tick();
    model_commit();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    sb_set_en = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [1:0] sel, input logic [AW-1:0] addr);
    rd_sel[2*p +: 2]   = sel;
    rd_addr[AW*p +: AW] = addr;
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    idle();
    wr_sel = 2'b00; wr_addr = '0; wr_data = '0;
    sb_set_sel = 2'b00; sb_set_addr = '0;
    set_port(0, 2'b01, 3'd0);
    set_port(1, 2'b00, 3'd3);
    #2 RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    n_tests++;
    if (rd_data[0 +: DW] !== 16'hBF00) begin
      n_fail++; $display("FAIL reset_sp: got %h expected %h", rd_data[0 +: DW], 16'hBF00);
    end
    n_tests++;
    if (rd_data[DW +: DW] !== 16'h0000) begin
      n_fail++; $display("FAIL reset_gp3: got %h expected %h", rd_data[DW +: DW], 16'h0000);
    end
    n_tests++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy: got %b expected %b", rd_busy, 2'b00);
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_bypass_gp();
    set_port(0, 2'b00, 3'd5);
    set_port(1, 2'b00, 3'd1);
    do_write(2'b00, 3'd5, 16'h1234);
    #1;
    n_tests++;
    if (rd_data[0 +: DW] !== 16'h1234) begin
      n_fail++; $display("FAIL bypass_gp5: got %h expected %h", rd_data[0 +: DW], 16'h1234);
    end
    n_tests++;
    if (rd_data[DW +: DW] !== 16'h0000) begin
      n_fail++; $display("FAIL bypass_other_port: got %h expected %h", rd_data[DW +: DW], 16'h0000);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_data[0 +: DW] !== 16'h1234) begin
      n_fail++; $display("FAIL stored_gp5: got %h expected %h", rd_data[0 +: DW], 16'h1234);
    end
  endtask

  task automatic test_special_write();
    set_port(0, 2'b00, 3'd2);
    set_port(1, 2'b11, 3'd0);
    do_write(2'b10, 3'd0, 16'h00AA);
    #1;
    n_tests++;
    if (rd_data[0 +: DW] !== 16'h0000) begin
      n_fail++; $display("FAIL ih_write_gp2: got %h expected %h", rd_data[0 +: DW], 16'h0000);
    end
    n_tests++;
    if (rd_data[DW +: DW] !== 16'h0000) begin
      n_fail++; $display("FAIL ih_write_t: got %h expected %h", rd_data[DW +: DW], 16'h0000);
    end
    tick();
    idle();
    set_port(0, 2'b10, 3'd7);
    #1;
    n_tests++;
    if (rd_data[0 +: DW] !== 16'h00AA) begin
      n_fail++; $display("FAIL ih_read_addr_ignored: got %h expected %h", rd_data[0 +: DW], 16'h00AA);
    end
  endtask

  task automatic test_scoreboard();
    sb_set_en = 1'b1; sb_set_sel = 2'b00; sb_set_addr = 3'd4;
    set_port(0, 2'b00, 3'd4);
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_set_not_yet_visible: got %b expected %b", rd_busy[0], 1'b0);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL sb_gp4_busy: got %b expected %b", rd_busy[0], 1'b1);
    end
    do_write(2'b00, 3'd4, 16'h0055);
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_gp4_bypass_busy: got %b expected %b", rd_busy[0], 1'b0);
    end
    n_tests++;
    if (rd_data[0 +: DW] !== 16'h0055) begin
      n_fail++; $display("FAIL sb_gp4_bypass_data: got %h expected %h", rd_data[0 +: DW], 16'h0055);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_gp4_cleared: got %b expected %b", rd_busy[0], 1'b0);
    end
  endtask

  task automatic test_set_clear_race();
    set_port(1, 2'b00, 3'd1);
    sb_set_en = 1'b1; sb_set_sel = 2'b00; sb_set_addr = 3'd1;
    do_write(2'b00, 3'd1, 16'hC0DE);
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL race_set_wins: got %b expected %b", rd_busy[1], 1'b1);
    end
    sb_set_en = 1'b1; sb_set_sel = 2'b00; sb_set_addr = 3'd1;
    do_write(2'b00, 3'd1, 16'hBEEF);
    flush = 1'b1;
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL race_flush_wins: got %b expected %b", rd_busy[1], 1'b0);
    end
    n_tests++;
    if (rd_data[DW +: DW] !== 16'hBEEF) begin
      n_fail++; $display("FAIL race_data: got %h expected %h", rd_data[DW +: DW], 16'hBEEF);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en       = 1'($urandom_range(0, 1));
      wr_sel      = 2'($urandom);
      wr_addr     = 3'($urandom);
      wr_data     = 16'($urandom);
      sb_set_en   = ($urandom_range(0, 2) == 0);
      sb_set_sel  = 2'($urandom);
      sb_set_addr = 3'($urandom);
      flush       = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 2) == 0) set_port(p, wr_sel, wr_addr);
        else set_port(p, 2'($urandom), 3'($urandom));
      end
      #1;
      for (int p = 0; p < NRD; p++) begin
        n_tests++;
        if (rd_data[DW*p +: DW] !== exp_data(p)) begin
          n_fail++;
          $display("FAIL rand_data cycle %0d port %0d: got %h expected %h", c, p, rd_data[DW*p +: DW], exp_data(p));
        end
        n_tests++;
        if (rd_busy[p] !== exp_busy(p)) begin
          n_fail++;
          $display("FAIL rand_busy cycle %0d port %0d: got %b expected %b", c, p, rd_busy[p], exp_busy(p));
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_write(2'b00, 3'd6, 16'hFFFF);
    sb_set_en = 1'b1; sb_set_sel = 2'b11; sb_set_addr = 3'd0;
    set_port(0, 2'b00, 3'd6);
    set_port(1, 2'b11, 3'd0);
    tick();
    idle();
    #1;
    n_tests++;
    if (rd_data[0 +: DW] !== 16'hFFFF || rd_busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_state: got %h/%b expected %h/%b", rd_data[0 +: DW], rd_busy[1], 16'hFFFF, 1'b1);
    end
    #1 RST_N = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (rd_data[0 +: DW] !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset_gp6: got %h expected %h", rd_data[0 +: DW], 16'h0000);
    end
    n_tests++;
    if (rd_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_t_busy: got %b expected %b", rd_busy[1], 1'b0);
    end
    set_port(1, 2'b01, 3'd0);
    #1;
    n_tests++;
    if (rd_data[DW +: DW] !== SP_INIT) begin
      n_fail++; $display("FAIL async_reset_sp: got %h expected %h", rd_data[DW +: DW], SP_INIT);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    rd_sel  = '0;
    rd_addr = '0;
    test_reset();
    test_bypass_gp();
    test_special_write();
    test_scoreboard();
    test_set_clear_race();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
